// File: rtl/ws2812_frame_tx_if.sv
// rtl/ws2812_frame_tx_if.sv - received I2C byte stream feeding the LED frame transmitter
interface ws2812_frame_tx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       start;
    logic       stop;

    modport master (
        output data,
        output data_valid,
        output start,
        output stop
    );

    modport slave (
        input data,
        input data_valid,
        input start,
        input stop
    );
endinterface

// File: rtl/ws2812_frame_tx.sv
// rtl/ws2812_frame_tx.sv - double-buffered WS2812 one-wire frame transmitter fed by an I2C byte stream
module ws2812_frame_tx #(
    parameter int LED_CNT = 3,
    parameter int T0H_CYC = 4,
    parameter int T1H_CYC = 8,
    parameter int BIT_CYC = 13,
    parameter int RES_CYC = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    ws2812_frame_tx_if.slave      bus,
    output logic                  led_o,
    output logic                  busy
);

    localparam int NBYTES  = LED_CNT * 3;
    localparam int WP_W    = $clog2(NBYTES + 1);
    localparam int IDX_W   = $clog2(NBYTES);
    localparam int CNT_MAX = (RES_CYC > BIT_CYC) ? RES_CYC : BIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_buf    [NBYTES];
    logic [7:0]         r_shadow [NBYTES];
    logic [WP_W-1:0]    r_wr_ptr;
    logic               r_written;
    logic               r_pending;

    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [2:0]         r_bit_idx;

    logic [WP_W-1:0]    w_wr_idx;
    logic               w_wr_en;
    logic               w_written_now;
    logic               w_commit;
    logic [7:0]         w_cur_byte;
    logic               w_bit;
    logic [CNT_W-1:0]   w_high_cyc;
    logic               w_high_done;
    logic               w_bit_done;
    logic               w_latch_done;
    logic               w_last_bit;

    // A start in the same cycle as a byte restarts the transaction, so the byte lands at index 0.
    assign w_wr_idx      = bus.start ? '0 : r_wr_ptr;
    assign w_wr_en       = bus.data_valid && (w_wr_idx < WP_W'(NBYTES));
    assign w_written_now = (bus.start ? 1'b0 : r_written) | w_wr_en;
    assign w_commit      = bus.stop & w_written_now;

    // Write buffer, saturating write pointer and per-transaction written flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBYTES; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_wr_ptr  <= '0;
            r_written <= 1'b0;
        end else begin
            if (w_wr_en) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (w_wr_idx == WP_W'(i)) begin
                        r_buf[i] <= bus.data;
                    end
                end
            end
            r_wr_ptr  <= w_wr_en ? (w_wr_idx + WP_W'(1)) : w_wr_idx;
            r_written <= bus.stop ? 1'b0 : w_written_now;
        end
    end

    // Pending frame request; a commit landing on the LOAD cycle wins so its byte is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_pending <= 1'b1;
        end else if (r_state == S_LOAD) begin
            r_pending <= 1'b0;
        end
    end

    // Select the byte currently being shifted out of the shadow buffer.
    always_comb begin
        w_cur_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_byte_idx == IDX_W'(i)) begin
                w_cur_byte = r_shadow[i];
            end
        end
    end

    assign w_bit        = w_cur_byte[r_bit_idx];
    assign w_high_cyc   = w_bit ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    assign w_high_done  = (r_cnt == (w_high_cyc - CNT_W'(1)));
    assign w_bit_done   = (r_cnt == CNT_W'(BIT_CYC - 1));
    assign w_latch_done = (r_cnt == CNT_W'(RES_CYC - 1));
    assign w_last_bit   = (r_byte_idx == IDX_W'(NBYTES - 1)) && (r_bit_idx == 3'd0);

    // TX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_pending) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_HIGH;
            S_HIGH:  if (w_high_done) w_state_nxt = S_LOW;
            S_LOW:   if (w_bit_done) w_state_nxt = w_last_bit ? S_LATCH : S_HIGH;
            S_LATCH: if (w_latch_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // TX outputs are decoded from the state alone so reset drops the line immediately.
    always_comb begin
        led_o = 1'b0;
        busy  = 1'b0;
        case (r_state)
            S_HIGH:  begin led_o = 1'b1; busy = 1'b1; end
            S_LOW:   busy = 1'b1;
            S_LATCH: busy = 1'b1;
            default: begin led_o = 1'b0; busy = 1'b0; end
        endcase
    end

    // Shadow load, bit-time counter and bit/byte position; the counter runs across HIGH and LOW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBYTES; i++) begin
                r_shadow[i] <= 8'h00;
            end
            r_cnt      <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= 3'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shadow   <= r_buf;
                    r_cnt      <= '0;
                    r_byte_idx <= '0;
                    r_bit_idx  <= 3'd7;
                end
                S_HIGH: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_LOW: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd0) begin
                            r_bit_idx <= 3'd7;
                            if (!w_last_bit) begin
                                r_byte_idx <= r_byte_idx + IDX_W'(1);
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    r_cnt <= w_latch_done ? '0 : (r_cnt + CNT_W'(1));
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// tb/tb_ws2812_frame_tx.sv - self-checking bench for ws2812_frame_tx against a frame-position reference model
module tb_ws2812_frame_tx;

    localparam int LED_CNT = 3;
    localparam int T0H_CYC = 4;
    localparam int T1H_CYC = 8;
    localparam int BIT_CYC = 13;
    localparam int RES_CYC = 500;
    localparam int NB      = LED_CNT * 3;
    localparam int NBITS   = LED_CNT * 24;
    localparam int FRAME   = NBITS * BIT_CYC + RES_CYC;

    logic clk;
    logic reset;
    logic led_o;
    logic busy;

    ws2812_frame_tx_if bus_if ();

    ws2812_frame_tx #(
        .LED_CNT (LED_CNT),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC),
        .RES_CYC (RES_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .led_o (led_o),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: write buffer, commit flag and the position inside the frame being sent.
    logic [7:0] m_buf    [NB];
    logic [7:0] m_shadow [NB];
    int         m_ptr;
    bit         m_written;
    bit         m_pending;
    bit         m_loading;
    bit         m_active;
    int         m_pos;
    int         m_frames = 0;
    int         dut_frames = 0;
    bit         mon_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_buf[i]    = 8'h00;
            m_shadow[i] = 8'h00;
        end
        m_ptr     = 0;
        m_written = 1'b0;
        m_pending = 1'b0;
        m_loading = 1'b0;
        m_active  = 1'b0;
        m_pos     = 0;
    endtask

    task automatic model_step(input bit s, input bit v, input logic [7:0] d, input bit p);
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 1'b0;
        end else if (m_loading) begin
            m_shadow  = m_buf;
            m_loading = 1'b0;
            m_active  = 1'b1;
            m_pos     = 0;
            m_pending = 1'b0;
            m_frames++;
        end else if (m_pending) begin
            m_loading = 1'b1;
        end
        if (s) begin
            m_ptr     = 0;
            m_written = 1'b0;
        end
        if (v && m_ptr < NB) begin
            m_buf[m_ptr] = d;
            m_ptr++;
            m_written = 1'b1;
        end
        if (p) begin
            if (m_written) m_pending = 1'b1;
            m_written = 1'b0;
        end
    endtask

    function automatic int exp_led();
        int b;
        int off;
        int v;
        if (!m_active) return 0;
        b = m_pos / BIT_CYC;
        if (b >= NBITS) return 0;
        off = m_pos % BIT_CYC;
        v = int'(m_shadow[b / 8][7 - (b % 8)]);
        return (off < (v != 0 ? T1H_CYC : T0H_CYC)) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step(bus_if.start, bus_if.data_valid, bus_if.data, bus_if.stop);
    end

    always @(posedge busy) dut_frames++;

    always @(negedge clk) begin
        if (mon_en) begin
            check("led_o", int'(led_o), exp_led());
            check("busy", int'(busy), m_active ? 1 : 0);
        end
    end

    task automatic drive(input bit s, input bit v, input logic [7:0] d, input bit p);
        @(negedge clk);
        bus_if.start      = s;
        bus_if.data_valid = v;
        bus_if.data       = d;
        bus_if.stop       = p;
        @(posedge clk);
        #1;
        bus_if.start      = 1'b0;
        bus_if.data_valid = 1'b0;
        bus_if.data       = 8'h00;
        bus_if.stop       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || m_active || m_pending || m_loading) && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check(tag, (k < 4 * FRAME) ? 1 : 0, 1);
        idle(3);
    endtask

    int k;
    int f0;

    initial begin
        model_reset();
        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.data_valid = 1'b0;
        bus_if.data       = 8'h00;
        bus_if.stop       = 1'b0;
        idle(4);
        reset = 1'b0;
        check("rst_led", int'(led_o), 0);
        check("rst_busy", int'(busy), 0);
        mon_en = 1'b1;

        // Quiet line with no traffic.
        idle(2000);
        check("idle_frames", dut_frames, 0);

        // MSB-first ordering and the two-cycle start latency.
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h80, 0);
        drive(0, 1, 8'h00, 0);
        drive(0, 1, 8'h01, 0);
        drive(0, 0, 8'h00, 1);
        k = 0;
        @(negedge clk);
        while (!led_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("rise_latency", k, 2);
        wait_idle("t2_done");

        // Overflowing bytes are dropped.
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 11; i++) drive(0, 1, 8'hFF, 0);
        drive(0, 0, 8'h00, 1);
        wait_idle("t3_done");

        // Partial update keeps the untouched bytes.
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < NB; i++) drive(0, 1, 8'h00, 0);
        drive(0, 0, 8'h00, 1);
        wait_idle("t4a_done");
        drive(1, 1, 8'hAA, 0);
        drive(0, 0, 8'h00, 1);
        wait_idle("t4b_done");

        // Commits during a frame collapse into one follow-on frame.
        f0 = dut_frames;
        drive(1, 1, 8'h0F, 0);
        drive(0, 0, 8'h00, 1);
        idle(300);
        drive(1, 1, 8'hF0, 0);
        drive(0, 0, 8'h00, 1);
        drive(1, 1, 8'h33, 0);
        drive(0, 1, 8'h5C, 1);
        wait_idle("t5_done");
        check("t5_frames", dut_frames - f0, 2);

        // Reset in the middle of bit 5 aborts at once and clears both buffers.
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < NB; i++) drive(0, 1, 8'($urandom_range(1, 255)), 0);
        drive(0, 0, 8'h00, 1);
        k = 0;
        while (!(m_active && m_pos >= 5 * BIT_CYC + 2) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_bit5", (k < 1000) ? 1 : 0, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_led", int'(led_o), 0);
        check("t6_async_busy", int'(busy), 0);
        idle(3);
        reset = 1'b0;
        f0 = dut_frames;
        idle(300);
        check("t6_no_output", dut_frames - f0, 0);
        drive(1, 1, 8'h00, 0);
        drive(0, 0, 8'h00, 1);
        wait_idle("t6_done");

        // Random transactions, including commits and stops without data while busy.
        for (int t = 0; t < 8; t++) begin
            int nb;
            nb = $urandom_range(0, NB + 2);
            drive(1, 0, 8'h00, 0);
            for (int i = 0; i < nb; i++) drive(0, 1, 8'($urandom), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            drive(0, 0, 8'h00, 1);
            idle($urandom_range(0, 1600));
        end
        wait_idle("rand_done");
        check("frame_count", dut_frames, m_frames);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
